// File: rtl/multicycle_control.sv
// Control FSM for a 16-bit multicycle datapath: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects and strobes combinationally from the current state.
module multicycle_control (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_ctl,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [15:0] instr_count
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    state_t             state_q;
    state_t             state_d;
    logic               illegal_q;
    logic [CNT_W-1:0]   count_q;

    logic is_rtype;
    logic is_addi;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bne;
    logic is_legal;

    // Opcode classes; 0000-0110 are R-type, 1100-1111 are illegal
    always_comb begin
        is_rtype = (opcode <= 4'd6);
        is_addi  = (opcode == 4'd7);
        is_lw    = (opcode == 4'd8);
        is_sw    = (opcode == 4'd9);
        is_beq   = (opcode == 4'd10);
        is_bne   = (opcode == 4'd11);
        is_legal = ~(opcode[3] & opcode[2]);
    end

    // Next state and datapath controls; everything stays low while reset is held
    always_comb begin
        state_d    = FETCH;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctl    = ALU_AND;
        instr_done = 1'b0;
        if (reset_n) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctl   = ALU_ADD;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end else begin
                        state_d  = FETCH;
                    end
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    alu_ctl   = ALU_ADD;
                    if (is_legal) begin
                        state_d = EXEC;
                    end else begin
                        instr_done = 1'b1;
                    end
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    if (is_rtype) begin
                        state_d = WB;
                        case (opcode)
                            4'd0:    alu_ctl = ALU_ADD;
                            4'd1:    alu_ctl = ALU_SUB;
                            4'd2:    alu_ctl = ALU_AND;
                            4'd3:    alu_ctl = ALU_OR;
                            4'd4:    alu_ctl = ALU_NOR;
                            4'd5:    alu_ctl = ALU_NAND;
                            default: alu_ctl = ALU_SLT;
                        endcase
                    end else if (is_addi || is_lw || is_sw) begin
                        alu_src_b = 2'b10;
                        alu_ctl   = ALU_ADD;
                        state_d   = is_addi ? WB : MEM;
                    end else if (is_beq || is_bne) begin
                        alu_ctl    = ALU_SUB;
                        pc_src     = 1'b1;
                        pc_write   = (is_beq & zero) | (is_bne & ~zero);
                        instr_done = 1'b1;
                    end
                end
                MEM: begin
                    iord      = 1'b1;
                    mem_read  = is_lw;
                    mem_write = is_sw;
                    if (!mem_ready) begin
                        state_d = MEM;
                    end else if (is_lw) begin
                        state_d = WB;
                    end else begin
                        instr_done = is_sw;
                    end
                end
                WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = is_rtype;
                    mem_to_reg = is_lw;
                    instr_done = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // State register, sticky illegal flag and retirement counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE && !is_legal) begin
                illegal_q <= 1'b1;
            end
            if (instr_done) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule
